spmv_row_mac: RTL
=================

Name: spmv_row_mac

Overview:
- Compute stage directly downstream of the SRAM0 vector/value buffer reader in the SpMV datapath.
- Latches the dense 256-bit input vector x (16 lanes x 16 bit) at job start, then consumes a CSR-ordered stream of nonzeros (value, column index, row-end flag).
- For each nonzero, multiplies the value by x[col] and accumulates per row. Emits one signed row result y[r] per row over a valid/ready handshake.

Parameters:
DATA_W, 16, width of matrix values and x elements (signed two's complement)
NUM_ELEM, 16, lanes in the input vector; column index width is log2(NUM_ELEM)
ACC_W, 40, accumulator and result width (signed)
ROW_W, 8, width of the output row index

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  asynchronous active-low reset
i_start  in  1  start a job; sampled only in IDLE
i_in_vector  in  DATA_W*NUM_ELEM  dense x; lane k = bits [k*DATA_W +: DATA_W]; sampled on accepted i_start
i_val_valid  in  1  nonzero beat valid
o_val_ready  out  1  block accepts beat
i_val  in  DATA_W  signed matrix value
i_col  in  log2(NUM_ELEM)  column index
i_row_last  in  1  beat is the last nonzero of its row
i_mat_last  in  1  beat is the last nonzero of the matrix
o_y_valid  out  1  row result valid
i_y_ready  in  1  consumer accepts result
o_y  out  ACC_W  signed row result
o_y_row  out  ROW_W  row index of o_y
o_busy  out  1  high in RUN and DRAIN
o_done  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset (async, i_rstn=0): state=IDLE; all outputs 0; x register, accumulator, row counter and pipeline valids cleared. Reset mid-job aborts the job immediately. No result is emitted afterwards.
- States:
  - IDLE: i_start=1 latches i_in_vector, clears acc and row counter, moves to RUN.
  - RUN: accepts beats. An accepted beat with i_mat_last=1 moves to DRAIN.
  - DRAIN: o_val_ready=0. Moves to DONE once the pipeline is empty and the final o_y has been accepted.
  - DONE: o_done=1 for one cycle, then IDLE.
- i_start outside IDLE is ignored.
- Beat accepted when i_val_valid && o_val_ready.
- Pipeline:
  - S1 (cycle t+1): registers product = i_val * x[i_col], signed, 2*DATA_W bits, plus the last flag.
  - S2 (cycle t+2): sign-extends the product to ACC_W and adds it to acc, two's-complement wrap, no saturation.
  - If the beat is row-last: o_y = acc + product, o_y_row = row counter, o_y_valid=1 in cycle t+2. In the same cycle acc clears to 0 and the row counter increments, wrapping mod 2^ROW_W.
- Latency: row-last beat accepted at t -> o_y_valid at t+2.
- Back-to-back non-last beats stream at 1/cycle.
- o_val_ready = (state==RUN) && no row-last beat in S1/S2 && !o_y_valid. This stalls input for 3 cycles minimum after each row-last beat, so a pending result is never overwritten.
- o_y_valid holds with o_y and o_y_row stable until i_y_ready=1. It drops the cycle after acceptance.
- i_mat_last=1 with i_row_last=0 is treated as row-last.
- An empty row must be sent upstream as one beat with i_val=0 and i_row_last=1; it yields o_y=0.
- i_col is always in range by width; no checking is required.
- x is constant for the whole job; i_in_vector changes after start have no effect.

Decomposition:
- Shared package: state encoding (IDLE/RUN/DRAIN/DONE, 2-bit) and defaults for DATA_W, NUM_ELEM, ACC_W, ROW_W; the same values are used by the upstream buffer reader.
- One natural sub-module: spmv_lane_mux, a combinational NUM_ELEM:1 select of x[i_col] from the latched vector.
- Multiply and accumulate stay in the top module.

Test Plan:
- Single row: x lanes k = k+1. Beats (val=2,col=0),(val=3,col=5),(val=-1,col=15,row_last,mat_last) -> o_y = 2*1 + 3*6 - 16 = 4, o_y_row=0, valid at t+2 of the last beat; o_done one cycle after acceptance.
- Three rows, the middle one empty (val=0,row_last): x all 0x0001, rows {1,1},{},{7} -> o_y 2, 0, 7 with o_y_row 0, 1, 2; o_val_ready low for 3 cycles after each row-last.
- Backpressure: hold i_y_ready=0 for 10 cycles on the first result -> o_y/o_y_row stable, o_val_ready=0 throughout, no beat lost, next row still correct.
- Extremes: 16 beats of val=-32768 times x=-32768 in one row -> o_y = 16*2^30 = 0x0400000000 (40-bit), no wrap.
- Reset mid-row: assert i_rstn=0 after 2 accepted beats -> o_y_valid=0, o_busy=0, state IDLE. A new job then starts with acc=0 and o_y_row=0.
- i_start pulsed during RUN with a different i_in_vector -> ignored; results use the originally latched x.

Source files
------------

// File: rtl/spmv_row_mac_pkg.sv
// Shared definitions for the SpMV row multiply-accumulate stage.
// The upstream SRAM0 buffer reader uses the same width defaults.
package spmv_row_mac_pkg;

    localparam int SPMV_DATA_W   = 16;
    localparam int SPMV_NUM_ELEM = 16;
    localparam int SPMV_ACC_W    = 40;
    localparam int SPMV_ROW_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/spmv_lane_mux.sv
// Selects one lane of the latched dense x vector by column index.
module spmv_lane_mux
    import spmv_row_mac_pkg::*;
#(
    parameter int DATA_W   = SPMV_DATA_W,
    parameter int NUM_ELEM = SPMV_NUM_ELEM
) (
    input  logic        [DATA_W*NUM_ELEM-1:0]   vec,
    input  logic        [$clog2(NUM_ELEM)-1:0]  sel,
    output logic signed [DATA_W-1:0]            lane
);

    logic [DATA_W-1:0] lanes [NUM_ELEM];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEM; gi++) begin : g_lane
            assign lanes[gi] = vec[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign lane = lanes[sel];

endmodule

// File: rtl/spmv_row_mac.sv
// SpMV row MAC: latches x at job start, multiplies each CSR nonzero by x[col]
// and emits one signed accumulated result per row over valid/ready.
module spmv_row_mac
    import spmv_row_mac_pkg::*;
#(
    parameter int DATA_W   = SPMV_DATA_W,
    parameter int NUM_ELEM = SPMV_NUM_ELEM,
    parameter int ACC_W    = SPMV_ACC_W,
    parameter int ROW_W    = SPMV_ROW_W
) (
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_start,
    input  logic        [DATA_W*NUM_ELEM-1:0] i_in_vector,
    input  logic                            i_val_valid,
    output logic                            o_val_ready,
    input  logic signed [DATA_W-1:0]        i_val,
    input  logic        [$clog2(NUM_ELEM)-1:0] i_col,
    input  logic                            i_row_last,
    input  logic                            i_mat_last,
    output logic                            o_y_valid,
    input  logic                            i_y_ready,
    output logic signed [ACC_W-1:0]         o_y,
    output logic        [ROW_W-1:0]         o_y_row,
    output logic                            o_busy,
    output logic                            o_done
);

    state_t state_reg, state_next;

    logic        [DATA_W*NUM_ELEM-1:0] x_reg;
    logic signed [DATA_W-1:0]          x_sel;
    logic                              s1_valid_reg;
    logic                              s1_last_reg;
    logic signed [2*DATA_W-1:0]        s1_prod_reg;
    logic signed [ACC_W-1:0]           acc_reg;
    logic signed [ACC_W-1:0]           prod_ext;
    logic signed [ACC_W-1:0]           acc_sum;
    logic                              y_valid_reg;
    logic signed [ACC_W-1:0]           y_reg;
    logic        [ROW_W-1:0]           y_row_reg;
    logic        [ROW_W-1:0]           row_reg;
    logic                              settle_reg;
    logic                              accept;
    logic                              start_ok;
    logic                              row_done;

    spmv_lane_mux #(
        .DATA_W   (DATA_W),
        .NUM_ELEM (NUM_ELEM)
    ) u_lane_mux (
        .vec  (x_reg),
        .sel  (i_col),
        .lane (x_sel)
    );

    // One bubble after each result handoff keeps the post-row stall at three cycles minimum.
    assign o_val_ready = (state_reg == RUN) && !(s1_valid_reg && s1_last_reg)
                         && !y_valid_reg && !settle_reg;
    assign accept      = i_val_valid && o_val_ready;
    assign start_ok    = (state_reg == IDLE) && i_start;
    assign row_done    = s1_valid_reg && s1_last_reg;
    assign prod_ext    = {{(ACC_W-2*DATA_W){s1_prod_reg[2*DATA_W-1]}}, s1_prod_reg};
    assign acc_sum     = acc_reg + prod_ext;

    assign o_y_valid = y_valid_reg;
    assign o_y       = y_reg;
    assign o_y_row   = y_row_reg;
    assign o_busy    = (state_reg == RUN) || (state_reg == DRAIN);
    assign o_done    = (state_reg == DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (accept && i_mat_last) state_next = DRAIN;
            // The final result must be handed off before the job is reported done.
            DRAIN:   if (!s1_valid_reg && (!y_valid_reg || i_y_ready)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg    <= IDLE;
            x_reg        <= '0;
            s1_valid_reg <= 1'b0;
            s1_last_reg  <= 1'b0;
            s1_prod_reg  <= '0;
            acc_reg      <= '0;
            y_valid_reg  <= 1'b0;
            y_reg        <= '0;
            y_row_reg    <= '0;
            row_reg      <= '0;
            settle_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            s1_valid_reg <= accept;
            settle_reg   <= y_valid_reg && i_y_ready;

            if (start_ok) begin
                x_reg   <= i_in_vector;
                acc_reg <= '0;
                row_reg <= '0;
            end

            if (accept) begin
                s1_prod_reg <= i_val * x_sel;
                s1_last_reg <= i_row_last || i_mat_last;
            end

            if (y_valid_reg && i_y_ready) begin
                y_valid_reg <= 1'b0;
            end

            if (row_done) begin
                y_reg       <= acc_sum;
                y_row_reg   <= row_reg;
                y_valid_reg <= 1'b1;
                acc_reg     <= '0;
                row_reg     <= row_reg + 1'b1;
            end else if (s1_valid_reg) begin
                acc_reg <= acc_sum;
            end
        end
    end

endmodule
